// File: rtl/disp_pkg.sv
// Shared constants for the two-digit multiplexed 7-segment display.
// Segment patterns are active-low {g,f,e,d,c,b,a}; digit enables are active-low.
package disp_pkg;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [1:0] AN_OFF   = 2'b11;
    localparam logic [1:0] AN_UNITS = 2'b10;
    localparam logic [1:0] AN_TENS  = 2'b01;

    typedef enum logic {
        DIGIT_UNITS = 1'b0,
        DIGIT_TENS  = 1'b1
    } digit_t;

endpackage

// File: rtl/bcd_7seg.sv
// BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module bcd_7seg
    import disp_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_0_99.sv
// Two-digit time-multiplexed 7-segment driver with per-frame input snapshot,
// leading-zero blanking and whole-display blinking. All outputs are registered.
module display_0_99
    import disp_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLINK_FRAMES = 25
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] units,
    input  logic [3:0] tens,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_FRAMES - 1);

    logic [RW-1:0] refresh_cnt;
    digit_t        digit_sel;
    logic [BW-1:0] blink_cnt;
    logic          blink_phase;
    logic [3:0]    snap_tens;
    logic [3:0]    snap_units;

    logic          slot_end;
    logic          frame_end;
    logic [3:0]    shown_digit;
    logic [6:0]    digit_pattern;
    logic [6:0]    seg_next;
    logic [1:0]    an_next;

    assign slot_end  = (refresh_cnt == REFRESH_LAST);
    assign frame_end = slot_end && (digit_sel == DIGIT_TENS);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            refresh_cnt <= '0;
            digit_sel   <= DIGIT_UNITS;
        end else if (slot_end) begin
            refresh_cnt <= '0;
            digit_sel   <= (digit_sel == DIGIT_UNITS) ? DIGIT_TENS : DIGIT_UNITS;
        end else begin
            refresh_cnt <= refresh_cnt + RW'(1);
        end
    end

    // Inputs are captured only at the frame boundary so a frame never mixes two values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_tens  <= 4'd0;
            snap_units <= 4'd0;
        end else if (frame_end) begin
            snap_tens  <= tens;
            snap_units <= units;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (!blink_en) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt   <= blink_cnt + BW'(1);
            end
        end
    end

    assign shown_digit = (digit_sel == DIGIT_TENS) ? snap_tens : snap_units;

    bcd_7seg u_decoder (
        .bcd (shown_digit),
        .seg (digit_pattern)
    );

    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_OFF;
        if (blink_phase &&
            !((digit_sel == DIGIT_TENS) && (snap_tens == 4'd0) && blank_lz)) begin
            an_next  = (digit_sel == DIGIT_TENS) ? AN_TENS : AN_UNITS;
            seg_next = digit_pattern;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            seg        <= SEG_OFF;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_next;
            an         <= an_next;
            frame_tick <= frame_end;
        end
    end

endmodule
